// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: active-low pattern type and hex glyph table.
// The display encoder and the scan-reader decoder both use this table.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  // Active-low patterns, bit6=g .. bit0=a, indexed by hex value
  localparam seg_t SEG_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000100, 7'b0001110
  };

  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seven_segment_pattern_to_hex.sv
// Inverse glyph lookup: segment pattern back to nibble, flagging blank and
// unrecognised patterns.
module seven_segment_pattern_to_hex
  import seven_seg_pkg::*;
(
  input  seg_t       seg,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err
);

  logic hit;

  always_comb begin
    nibble = '0;
    hit    = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg == SEG_HEX[i]) begin
        nibble = 4'(i);
        hit    = 1'b1;
      end
    end
    blank = (seg == SEG_BLANK);
    err   = !hit && !blank;
  end

endmodule

// File: rtl/seven_segment_scan_reader.sv
// Snoops a multiplexed active-low seven-segment bus, debounces each digit's
// dwell, and presents every completed frame on a valid/ready output.
module seven_segment_scan_reader #(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [N_DIGITS-1:0]   digit_sel,
  output logic [4*N_DIGITS-1:0] value,
  output logic [N_DIGITS-1:0]   blank_mask,
  output logic [N_DIGITS-1:0]   err_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow
);

  import seven_seg_pkg::*;

  localparam int IDXW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNTW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(STABLE_CYCLES);

  logic [IDXW-1:0]     sel_idx, prev_idx;
  seg_t                prev_seg;
  logic                qualified, same, held_flag, capture, complete;
  logic [CNTW-1:0]     cnt, cnt_next;
  logic                captured, captured_next;

  logic [3:0]          dec_nib;
  logic                dec_blank, dec_err;

  logic [3:0]          slot_nib [N_DIGITS];
  logic [N_DIGITS-1:0] slot_blank, slot_err, seen, seen_cap, cap_onehot;

  logic [4*N_DIGITS-1:0] frame_val;
  logic [N_DIGITS-1:0]   frame_blank, frame_err;

  seven_segment_pattern_to_hex u_dec (
    .seg    (seg_in),
    .nibble (dec_nib),
    .blank  (dec_blank),
    .err    (dec_err)
  );

  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (!digit_sel[i]) sel_idx = IDXW'(i);
    end
    qualified = $onehot(~digit_sel);
  end

  // The captured flag only survives while the same (index, pattern) persists
  always_comb begin
    same      = (sel_idx == prev_idx) && (seg_in == prev_seg);
    held_flag = captured && same;
    if (!qualified)
      cnt_next = '0;
    else if (same)
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    else
      cnt_next = CNTW'(1);
    capture       = qualified && (cnt_next == CNT_MAX) && !held_flag;
    captured_next = qualified && (held_flag || capture);
  end

  // Frame assembly bypasses the slot being written so completion loads at once
  always_comb begin
    cap_onehot  = '0;
    frame_val   = '0;
    frame_blank = '0;
    frame_err   = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (capture && sel_idx == IDXW'(i)) begin
        cap_onehot[i]      = 1'b1;
        frame_val[4*i +: 4] = dec_nib;
        frame_blank[i]     = dec_blank;
        frame_err[i]       = dec_err;
      end else begin
        frame_val[4*i +: 4] = slot_nib[i];
        frame_blank[i]     = slot_blank[i];
        frame_err[i]       = slot_err[i];
      end
    end
    seen_cap = seen | cap_onehot;
    complete = capture && (&seen_cap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_idx   <= '0;
      prev_seg   <= '0;
      cnt        <= '0;
      captured   <= 1'b0;
      seen       <= '0;
      slot_blank <= '0;
      slot_err   <= '0;
      for (int unsigned i = 0; i < N_DIGITS; i++) slot_nib[i] <= '0;
      value      <= '0;
      blank_mask <= '0;
      err_mask   <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      prev_idx <= sel_idx;
      prev_seg <= seg_in;
      cnt      <= cnt_next;
      captured <= captured_next;
      if (capture) begin
        slot_nib[sel_idx]   <= dec_nib;
        slot_blank[sel_idx] <= dec_blank;
        slot_err[sel_idx]   <= dec_err;
      end
      seen <= complete ? '0 : seen_cap;
      if (complete) begin
        if (out_valid && !out_ready) begin
          overflow <= 1'b1;
        end else begin
          value      <= frame_val;
          blank_mask <= frame_blank;
          err_mask   <= frame_err;
          out_valid  <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seven_segment_scan_reader.md
Name: seven_segment_scan_reader

Overview:
- Reverse path of the board's seven-segment display: snoops a multiplexed active-low segment bus plus anode selects and recovers the hex word being shown.
- Used for on-board loopback and self-check of the booth multiplier result display.
- Debounces each digit's dwell, converts each segment pattern back to a nibble, and assembles a full frame.
- Presents each completed frame on a valid/ready output.

Parameters:
- N_DIGITS, 4, number of multiplexed digits (≥1).
- STABLE_CYCLES, 4, consecutive identical cycles required before a digit is captured (≥1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- seg_in  input  7  segment pattern, active-low, bit0=a … bit6=g.
- digit_sel  input  N_DIGITS  anode enables, active-low; bit i selects digit i (digit 0 = least-significant nibble).
- value  output  4*N_DIGITS  recovered hex word.
- blank_mask  output  N_DIGITS  bit i set if digit i was blank (1111111).
- err_mask  output  N_DIGITS  bit i set if digit i had an unrecognised pattern.
- out_valid  output  1  frame available.
- out_ready  input  1  consumer accepts frame.
- overflow  output  1  sticky: a frame completed while out_valid && !out_ready.

Behaviour:
- Reset: all outputs 0. Seen-mask, stability counter, captured flag and digit registers are all cleared.
- Reset has priority over every other event, including mid-frame and mid-handshake; everything restarts clean.
- Select qualification:
  - Qualified only when exactly one digit_sel bit is 0.
  - Otherwise (none low, or several low): no capture, stability counter cleared, captured flag cleared.
- Stability:
  - Register the previous cycle's (index, seg_in).
  - Counter increments (saturating at STABLE_CYCLES) while index and pattern equal the previous cycle; otherwise it reloads to 1.
  - Capture fires on the cycle the count reaches STABLE_CYCLES, if the captured flag is clear. The flag is then set.
  - The flag clears when the index or pattern changes, or when the select becomes unqualified. Result: one capture per dwell.
  - STABLE_CYCLES=1 captures on the first qualified cycle.
- Decode (combinational):
  - Patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000100, F=0001110.
  - 1111111 → nibble 0, blank=1.
  - Any other pattern → nibble 0, err=1.
- Capture: writes nibble, blank and err into the slot for that index and sets seen[index]. A re-capture of an already-seen index overwrites its slot.
- Frame completion: the capture makes seen all-ones.
  - The next cycle, value, blank_mask and err_mask load from the slots (including the just-captured digit) and out_valid=1.
  - seen clears in the same cycle.
  - If out_valid=1 and out_ready=0 at completion: frame dropped, outputs unchanged, overflow←1 (cleared only by rst). seen still clears.
- Handshake:
  - out_valid holds, with value, blank_mask and err_mask stable, until the cycle out_valid && out_ready.
  - out_valid falls the next cycle unless a completion coincides. In that case the new frame loads and out_valid stays 1, with no overflow.
- Latency: last-digit dwell start → out_valid = STABLE_CYCLES cycles.

Decomposition:
- Package seven_seg_pkg:
  - typedef seg_t (logic [6:0]).
  - Constant array SEG_HEX[16] holding the pattern table.
  - Constant SEG_BLANK.
  - Shared with the display decoder.
- Sub-module seven_segment_pattern_to_hex: seg_t in → nibble, blank, err. Purely combinational; the inverse table only.

Test Plan:
- N=4, S=4. Each digit held for 6 cycles, patterns for 3,2,1,0 on digits 3..0, out_ready=1 → out_valid=1 once, value=16'h3210, masks 0, overflow 0.
- Digit 1 driven 0001000 for 2 cycles then 0100001 for 4 cycles; others 0 → digit 1 captures d only; value=16'h00d0.
- Digit 2 pattern 1010101 → err_mask=4'b0100, nibble 0. Digit 3 pattern 1111111 → blank_mask=4'b1000.
- out_ready=0; two full frames 16'hABCD then 16'h1234 → value stays 16'hABCD, overflow=1. Raise out_ready → one transfer, then out_valid=0.
- digit_sel=4'b1100 (two low) for 10 cycles → no capture, seen unchanged. rst asserted after 3 digits captured → 4th digit alone yields no frame.
